// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcode and state encodings for the accumulator ALU.
// Contents : alu_op_e    - 4-bit operation select
//            alu_state_e - control FSM states (IDLE, MUL, DONE)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_PASSACC = 4'd0,
        OP_ADD     = 4'd1,
        OP_SUB     = 4'd2,
        OP_AND     = 4'd3,
        OP_OR      = 4'd4,
        OP_XOR     = 4'd5,
        OP_LOAD    = 4'd6,
        OP_SHL     = 4'd7,
        OP_SHR     = 4'd8,
        OP_MUL     = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_acc_if
// Purpose  : Operation/result handshake bundle for alu_acc.
// Ports    : in_valid/in_ready/opcode/data   - operation request channel
//            out_valid/out_ready/alu_out     - result channel
//            zero/carry/neg                  - result flags
// Modports : master (request producer / result consumer), slave (alu_acc)
// Revision : 1.0 - initial release
// ============================================================================
interface alu_acc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             zero;
    logic             carry;
    logic             neg;

    modport master (
        output in_valid, opcode, data, out_ready,
        input  in_ready, out_valid, alu_out, zero, carry, neg
    );

    modport slave (
        input  in_valid, opcode, data, out_ready,
        output in_ready, out_valid, alu_out, zero, carry, neg
    );
endinterface
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Purpose  : Iterative shift-add unsigned multiplier, one multiplier bit per
//            cycle, WIDTH cycles per product.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            start_i        - load operands and process bit 0 this cycle
//            a_i, b_i       - multiplicand, multiplier
//            done_o         - product_o is complete (high for one cycle)
//            product_o      - full 2*WIDTH-bit product
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 start_i,
    input  wire logic [WIDTH-1:0]     a_i,
    input  wire logic [WIDTH-1:0]     b_i,
    output logic                      done_o,
    output logic [2*WIDTH-1:0]        product_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;

    // Bit 0 is folded into the start cycle so the remaining WIDTH-1 bits
    // finish exactly WIDTH cycles after start; done then lines up with the
    // controller's final MUL cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            prod_q   <= b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i} << 1;
            mplier_q <= b_i >> 1;
            cnt_q    <= CNT_W'(WIDTH - 1);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                prod_q   <= prod_q + (mplier_q[0] ? mcand_q : '0);
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CNT_W'(1);
            end else begin
                busy_q   <= 1'b0;
            end
        end
    end

    assign done_o    = busy_q && (cnt_q == '0);
    assign product_o = prod_q;

endmodule
`default_nettype wire

// File: rtl/alu_acc.sv
`default_nettype none
// ============================================================================
// Module   : alu_acc
// Purpose  : Accumulator ALU with valid/ready handshakes. Operand A is the
//            internal accumulator, operand B is bus.data. Single-cycle ops
//            complete with latency 1; MUL (MUL_EN=1) runs iteratively.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            bus  - alu_acc_if.slave (request, result and flags)
// Revision : 1.0 - initial release
// ============================================================================
module alu_acc
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    alu_acc_if.slave   bus
);
    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               neg_q, neg_d;

    logic               accept;
    logic               is_mul;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cy;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign accept = bus.in_valid && bus.in_ready;
    assign is_mul = (MUL_EN != 0) && (bus.opcode == OP_MUL);
    assign sum    = {1'b0, acc_q} + {1'b0, bus.data};

    // Single-cycle datapath; MUL with MUL_EN=0 and opcodes 10-15 fall to
    // the default and pass the accumulator through with carry cleared.
    always_comb begin
        alu_res = acc_q;
        alu_cy  = 1'b0;
        case (bus.opcode)
            OP_ADD:  begin alu_res = sum[WIDTH-1:0];            alu_cy = sum[WIDTH];            end
            OP_SUB:  begin alu_res = acc_q - bus.data;          alu_cy = (acc_q < bus.data);    end
            OP_AND:  alu_res = acc_q & bus.data;
            OP_OR:   alu_res = acc_q | bus.data;
            OP_XOR:  alu_res = acc_q ^ bus.data;
            OP_LOAD: alu_res = bus.data;
            OP_SHL:  begin alu_res = {acc_q[WIDTH-2:0], 1'b0};  alu_cy = acc_q[WIDTH-1];        end
            OP_SHR:  begin alu_res = {1'b0, acc_q[WIDTH-1:1]};  alu_cy = acc_q[0];              end
            default: ;
        endcase
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
                .clk       (clk),
                .rst       (rst),
                .start_i   (mul_start),
                .a_i       (acc_q),
                .b_i       (bus.data),
                .done_o    (mul_done),
                .product_o (mul_prod)
            );
        end else begin : g_no_mul
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    // Accumulator and flags only change on the edge that enters DONE, so
    // they stay frozen while a result waits for out_ready.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        neg_d     = neg_q;
        mul_start = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (is_mul) begin
                        mul_start = 1'b1;
                        state_d   = S_MUL;
                    end else begin
                        acc_d   = alu_res;
                        carry_d = alu_cy;
                        zero_d  = (alu_res == '0);
                        neg_d   = alu_res[WIDTH-1];
                        state_d = S_DONE;
                    end
                end else if (state_q == S_DONE && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    acc_d   = mul_prod[WIDTH-1:0];
                    carry_d = |mul_prod[2*WIDTH-1:WIDTH];
                    zero_d  = (mul_prod[WIDTH-1:0] == '0);
                    neg_d   = mul_prod[WIDTH-1];
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && bus.out_ready);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.alu_out   = acc_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.neg       = neg_q;

endmodule
`default_nettype wire

// File: doc/alu_acc.md
ALU_ACC -- requirements
Module: alu_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8: datapath, accumulator and result width (WIDTH >= 4).
REQ-002 SHALL have parameter MUL_EN, default 1: 1 implements MUL; 0 makes MUL behave as PASSACC.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  opcode and data are valid this cycle.
REQ-007 in_ready  output  1  block accepts an operation this cycle.
REQ-008 opcode  input  4  operation select (REQ-014).
REQ-009 data  input  WIDTH  operand B; the internal accumulator is operand A.
REQ-010 out_valid  output  1  result and flags are valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 alu_out  output  WIDTH  result, equal to the new accumulator value.
REQ-013 zero, carry, neg  output  1 each  result flags.

Function
REQ-014 Opcodes SHALL be:
- 0 PASSACC
- 1 ADD: A+B
- 2 SUB: A-B
- 3 AND
- 4 OR
- 5 XOR
- 6 LOAD: B
- 7 SHL: A<<1
- 8 SHR: A>>1, logical
- 9 MUL: low WIDTH bits of A*B
- 10-15: PASSACC.
REQ-015 An operation is accepted on a rising edge where in_valid && in_ready.
REQ-016 The accumulator SHALL be written with the result when out_valid rises. It SHALL hold its value at all other times.
REQ-017 Flags:
- zero = (result == 0).
- neg = result MSB.
- carry for ADD = carry-out of bit WIDTH-1.
- carry for SUB = borrow (A < B, unsigned).
- carry for SHL = shifted-out MSB; for SHR = shifted-out LSB.
- carry for MUL = 1 if any upper product bit is nonzero.
- carry for all other ops = 0.
REQ-018 State machine states are IDLE, MUL, DONE.
REQ-019 IDLE: in_ready=1. Accepting a non-MUL op goes to DONE; out_valid is asserted the cycle after acceptance (latency 1).
REQ-020 IDLE: accepting MUL with MUL_EN=1 goes to MUL. The multiply is iterative shift-add, one multiplier bit per cycle, and runs for exactly WIDTH cycles before entering DONE. out_valid is asserted WIDTH+1 cycles after acceptance.
REQ-021 MUL: in_ready=0 and out_valid=0. in_valid is ignored.
REQ-022 DONE: out_valid=1. alu_out and flags stay stable until out_ready=1.
REQ-023 DONE with out_ready=1: in_ready=1. If in_valid=1 in the same cycle, the new op is accepted (back-to-back, no bubble) and the next state follows REQ-019/REQ-020. Otherwise the next state is IDLE.
REQ-024 DONE with out_ready=0: in_ready=0.
REQ-025 out_ready is ignored when out_valid=0.
REQ-026 All arithmetic SHALL be unsigned modulo 2^WIDTH. Results SHALL be truncated, never widened.

Reset
REQ-027 With rst=1 at a clock edge, the block SHALL go to IDLE, clear the accumulator, and drive:
- alu_out=0, zero=1, carry=0, neg=0
- out_valid=0
- in_ready=1 from the first cycle after reset.
REQ-028 Reset SHALL win over any simultaneous handshake. A reset during MUL or DONE SHALL abandon the operation with no output produced.

Structure
REQ-029 Opcode encodings and state encodings SHALL live in shared package alu_pkg.
REQ-030 The iterative multiplier SHALL be one sub-module, alu_mul_seq, with start/done handshake and a WIDTH parameter.
REQ-031 Outputs SHALL be registered; no combinational path from data or opcode to alu_out or the flags.

Verification (WIDTH=8)
REQ-032 Reset; then LOAD 0x05 -> one cycle later out_valid=1, alu_out=0x05, zero=0, carry=0.
REQ-033 acc=0xFF, ADD 0x01 -> alu_out=0x00, zero=1, carry=1. Then SUB 0x01 -> 0xFF, carry=1, neg=1.
REQ-034 acc=0x0C, MUL 0x0B -> in_ready=0 for 8 cycles; out_valid exactly 9 cycles after acceptance; alu_out=0x84, carry=0. Repeat with acc=0x20, MUL 0x10 -> 0x00, carry=1, zero=1.
REQ-035 Hold out_ready=0 for 3 cycles in DONE -> alu_out, flags and out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 (XOR 0xFF) -> accepted that cycle, next result valid on the following cycle.
REQ-036 Assert rst on the 4th cycle of MUL -> out_valid=0 and alu_out=0 the next cycle; in_ready=1; a subsequent LOAD 0x33 returns 0x33.
